// File: rtl/agc_fetch.sv
// agc_fetch: instruction fetch unit for the AGC core.
// Drives the 12-bit fetch address, keeps at most one read outstanding to
// instruction memory, and hands 15-bit words to the decoder through a
// 2-entry buffer.  Each delivered word carries the extracode state set up
// by a preceding EXTEND, so the decoder need not track EXTEND itself.
// Execute-stage redirects flush the buffer and restart fetch; a response
// still in flight when the redirect lands is dropped on arrival.
//
// Handshake: a word moves from fetch to decoder on a cycle where
// instr_valid=1 and instr_ready=1 at the rising edge.  instr_valid never
// depends on instr_ready, and instr/instr_pc/instr_extra are stable while
// instr_valid=1 and the word is not taken.
`timescale 1ns/1ps

module agc_fetch #(
    parameter logic [11:0] RESET_PC = 12'o4000
) (
    input  logic        clock,
    input  logic        rst_l,
    output logic        imem_req,
    output logic [11:0] imem_addr,
    input  logic        imem_ack,
    input  logic [14:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [14:0] instr,
    output logic [11:0] instr_pc,
    output logic        instr_extra,
    input  logic        redirect,
    input  logic [11:0] redirect_pc,
    input  logic        halt
);

    localparam logic [14:0] EXTEND_WORD = 15'o00006;

    // IDLE: nothing outstanding.  WAIT: outstanding and wanted.
    // DISCARD: outstanding but stale (a redirect happened since issue).
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [11:0] r_pc;        // next address to fetch
    logic [11:0] r_req_pc;    // address of the outstanding request
    logic [1:0]  r_count;     // words held in the buffer (0..2)
    logic [11:0] r_buf0_pc;   // entry 0 is always the head
    logic [14:0] r_buf0_word;
    logic [11:0] r_buf1_pc;
    logic [14:0] r_buf1_word;
    logic        r_extend;    // extracode state for the head word

    logic        w_issue;
    logic        w_push;
    logic        w_pop;
    logic [14:0] w_head_word;

    // INDEX opcode: top octal digit 5 with bits 11:10 clear.
    function automatic logic is_index(input logic [14:0] word);
        return (word[14:12] == 3'o5) && (word[11:10] == 2'b00);
    endfunction

    // A word lands in the buffer only when the wanted response arrives and
    // no redirect is flushing the buffer in the same cycle.
    assign w_push      = (r_state == ST_WAIT) && imem_ack && !redirect;
    assign w_pop       = instr_valid && instr_ready;
    assign w_head_word = r_buf0_word;

    // Fetch FSM next-state and request decode.  The request is decoded in
    // the same cycle the FSM sits in IDLE so that the first read appears in
    // the first cycle out of reset; halt, redirect and reset gate it here.
    // Issue only needs count<2 because nothing is outstanding in IDLE, so
    // the returning word always has a free slot.
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (rst_l && !halt && !redirect && (r_count < 2'd2)) begin
                    w_issue     = 1'b1;
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_ack) begin
                    w_state_nxt = ST_IDLE;
                end else if (redirect) begin
                    w_state_nxt = ST_DISCARD;
                end
            end
            ST_DISCARD: begin
                if (imem_ack) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clock) begin
        if (!rst_l) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Fetch PC: redirect wins; otherwise step past each issued address,
    // wrapping naturally at 12 bits.
    always_ff @(posedge clock) begin
        if (!rst_l) begin
            r_pc     <= RESET_PC;
            r_req_pc <= '0;
        end else begin
            if (redirect) begin
                r_pc <= redirect_pc;
            end else if (w_issue) begin
                r_pc <= r_pc + 12'd1;
            end
            if (w_issue) begin
                r_req_pc <= r_pc;
            end
        end
    end

    // Two-entry buffer with entry 0 as head.  Entries are never cleared on
    // pop or flush, so an empty buffer keeps showing the last head value.
    always_ff @(posedge clock) begin
        if (!rst_l) begin
            r_count     <= 2'd0;
            r_buf0_pc   <= '0;
            r_buf0_word <= '0;
            r_buf1_pc   <= '0;
            r_buf1_word <= '0;
        end else if (redirect) begin
            r_count <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_buf0_pc   <= r_req_pc;
                        r_buf0_word <= imem_rdata;
                    end else begin
                        r_buf1_pc   <= r_req_pc;
                        r_buf1_word <= imem_rdata;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    if (r_count == 2'd2) begin
                        r_buf0_pc   <= r_buf1_pc;
                        r_buf0_word <= r_buf1_word;
                    end
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    // Count stays the same; with count=2 this cannot occur
                    // but shifting keeps the order right regardless.
                    if (r_count == 2'd2) begin
                        r_buf0_pc   <= r_buf1_pc;
                        r_buf0_word <= r_buf1_word;
                        r_buf1_pc   <= r_req_pc;
                        r_buf1_word <= imem_rdata;
                    end else begin
                        r_buf0_pc   <= r_req_pc;
                        r_buf0_word <= imem_rdata;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Extracode flag: changes only when a word is accepted, so the head
    // always sees the value that applies to it.  INDEX leaves it alone.
    always_ff @(posedge clock) begin
        if (!rst_l) begin
            r_extend <= 1'b0;
        end else if (redirect) begin
            r_extend <= 1'b0;
        end else if (w_pop) begin
            if (w_head_word == EXTEND_WORD) begin
                r_extend <= 1'b1;
            end else if (!is_index(w_head_word)) begin
                r_extend <= 1'b0;
            end
        end
    end

    assign imem_req    = w_issue;
    assign imem_addr   = r_pc;
    assign instr_valid = (r_count != 2'd0);
    assign instr       = r_buf0_word;
    assign instr_pc    = r_buf0_pc;
    assign instr_extra = r_extend;

endmodule

// File: tb/tb_agc_fetch.sv
// tb_agc_fetch: bench for agc_fetch.  A memory model answers requests with
// a programmable latency; a queue-based model of the fetch behaviour is
// compared against the DUT every cycle, and directed scenarios check
// hand-computed addresses, ordering and extracode tags from logs.
`timescale 1ns/1ps

module tb_agc_fetch;

    localparam logic [11:0] RST_PC = 12'o4000;

    // ---------------- clock / DUT ----------------
    logic        clock;
    logic        rst_l;
    logic        imem_req;
    logic [11:0] imem_addr;
    logic        imem_ack;
    logic [14:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [14:0] instr;
    logic [11:0] instr_pc;
    logic        instr_extra;
    logic        redirect;
    logic [11:0] redirect_pc;
    logic        halt;

    agc_fetch #(.RESET_PC(RST_PC)) dut (
        .clock       (clock),
        .rst_l       (rst_l),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_extra (instr_extra),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- counters / check helper ----------------
    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0o expected %0o (time %0t)", name, act, exp, $time);
    endtask

    // ---------------- stimulus knobs ----------------
    bit          k_rst        = 1'b1;
    int          k_ready_mode = 0;   // 0 always ready, 1 random, 2 never
    int          k_halt_mode  = 0;   // 0 off, 1 on, 2 random
    int          k_redir_pct  = 0;
    bit          k_redir_now  = 1'b0;
    logic [11:0] k_redir_pc   = '0;
    int          k_lat_min    = 1;
    int          k_lat_max    = 1;
    int          k_mem_mode   = 0;   // 0 word=addr, 1 mem_arr contents

    // ---------------- memory model ----------------
    logic [14:0] mem_arr [4096];
    logic [11:0] pend_addr[$];
    int          pend_due[$];
    int          last_due = 0;
    int          cyc = 0;
    int          rel = 0;

    function automatic logic [14:0] word_at(input logic [11:0] a);
        if (k_mem_mode == 0) return {3'b000, a};
        return mem_arr[a];
    endfunction

    task automatic fill_mem();
        for (int i = 0; i < 4096; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r == 0)      mem_arr[i] = 15'o00006;
            else if (r == 1) mem_arr[i] = {3'o5, 2'b00, 10'($urandom)};
            else             mem_arr[i] = 15'($urandom);
        end
    endtask

    // ---------------- behavioural model / scoreboard ----------------
    logic [26:0] exp_q[$];          // {pc, word} words waiting for the decoder
    logic [26:0] m_last;            // what the head showed last time it had a word
    logic [11:0] m_pc;
    logic [11:0] m_req_pc;
    bit          m_out;             // a request is in flight
    bit          m_stale;           // its answer must be thrown away
    bit          m_ext;
    bit          model_live = 1'b0;
    bit          e_req;
    bit          e_valid;
    logic [26:0] e_head;
    logic [26:0] popped;

    // ---------------- logs for directed checks ----------------
    logic [11:0] req_log[$];
    logic [27:0] del_log[$];        // {extra, pc, word}
    int          first_valid_rel = 0;

    function automatic logic [31:0] req_at(input int i);
        if (i < req_log.size()) return 32'(req_log[i]);
        return 32'hFFFF_FFFF;
    endfunction
    function automatic logic [31:0] del_pc_at(input int i);
        if (i < del_log.size()) return 32'(del_log[i][26:15]);
        return 32'hFFFF_FFFF;
    endfunction
    function automatic logic [31:0] del_word_at(input int i);
        if (i < del_log.size()) return 32'(del_log[i][14:0]);
        return 32'hFFFF_FFFF;
    endfunction
    function automatic logic [31:0] del_extra_at(input int i);
        if (i < del_log.size()) return 32'(del_log[i][27]);
        return 32'hFFFF_FFFF;
    endfunction

    // ---------------- per-cycle driver, memory and compare ----------------
    initial begin
        rst_l = 1'b0; imem_ack = 1'b0; imem_rdata = '0; instr_ready = 1'b1;
        redirect = 1'b0; redirect_pc = '0; halt = 1'b0;
        forever begin
            @(negedge clock);
            cyc++;
            // drive inputs for this cycle
            rst_l = !k_rst;
            case (k_ready_mode)
                0:       instr_ready = 1'b1;
                1:       instr_ready = ($urandom_range(0, 99) < 60);
                default: instr_ready = 1'b0;
            endcase
            case (k_halt_mode)
                0:       halt = 1'b0;
                1:       halt = 1'b1;
                default: halt = ($urandom_range(0, 99) < 15);
            endcase
            redirect_pc = 12'($urandom);
            if (k_redir_now) begin
                redirect    = 1'b1;
                redirect_pc = k_redir_pc;
                k_redir_now = 1'b0;
            end else if (k_redir_pct > 0 && $urandom_range(0, 99) < k_redir_pct) begin
                redirect = 1'b1;
                if ($urandom_range(0, 3) == 0) redirect_pc = 12'o7776 + 12'($urandom_range(0, 1));
            end else begin
                redirect = 1'b0;
            end
            if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
                imem_ack   = 1'b1;
                imem_rdata = word_at(pend_addr[0]);
                void'(pend_addr.pop_front());
                void'(pend_due.pop_front());
            end else begin
                imem_ack   = 1'b0;
                imem_rdata = 15'($urandom);
            end
            #1;
            if (rst_l) rel++; else rel = 0;

            // memory accepts a request
            if (imem_req === 1'b1) begin
                int due;
                due = cyc + $urandom_range(k_lat_min, k_lat_max);
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                pend_addr.push_back(imem_addr);
                pend_due.push_back(due);
            end

            // compare against the model
            if (model_live) begin
                e_req   = rst_l && !m_out && !halt && !redirect && (exp_q.size() < 2);
                e_valid = (exp_q.size() != 0);
                e_head  = e_valid ? exp_q[0] : m_last;
                chk("imem_req",    imem_req,    e_req);
                chk("imem_addr",   imem_addr,   m_pc);
                chk("instr_valid", instr_valid, e_valid);
                chk("instr",       instr,       e_head[14:0]);
                chk("instr_pc",    instr_pc,    e_head[26:15]);
                chk("instr_extra", instr_extra, m_ext);
            end else begin
                e_req = 1'b0; e_valid = 1'b0;
            end

            // logs
            if (rst_l && imem_req === 1'b1) req_log.push_back(imem_addr);
            if (rst_l && instr_valid === 1'b1 && instr_ready)
                del_log.push_back({instr_extra, instr_pc, instr});
            if (rst_l && instr_valid === 1'b1 && first_valid_rel == 0) first_valid_rel = rel;

            // advance the model to the next cycle
            if (!rst_l) begin
                exp_q.delete();
                m_last = '0; m_pc = RST_PC; m_req_pc = '0;
                m_out = 1'b0; m_stale = 1'b0; m_ext = 1'b0;
                model_live = 1'b1;
            end else if (model_live) begin
                if (e_valid) m_last = exp_q[0];
                if (e_valid && instr_ready) begin
                    popped = exp_q.pop_front();
                    if (popped[14:0] == 15'o00006) m_ext = 1'b1;
                    else if (!(popped[14:12] == 3'o5 && popped[11:10] == 2'b00)) m_ext = 1'b0;
                end
                if (m_out && imem_ack) begin
                    if (!m_stale && !redirect) exp_q.push_back({m_req_pc, imem_rdata});
                    m_out = 1'b0;
                end else if (m_out && redirect) begin
                    m_stale = 1'b1;
                end
                if (e_req) begin
                    m_out = 1'b1; m_stale = 1'b0; m_req_pc = m_pc; m_pc = m_pc + 12'd1;
                end
                if (redirect) begin
                    exp_q.delete();
                    m_ext = 1'b0;
                    m_pc  = redirect_pc;
                end
            end
        end
    end

    // ---------------- sequencer ----------------
    task automatic run(input int n);
        repeat (n) @(posedge clock);
    endtask

    task automatic do_reset();
        k_rst = 1'b1;
        run(6);
        #1;
        chk("reset_imem_req",    imem_req,    1'b0);
        chk("reset_imem_addr",   imem_addr,   RST_PC);
        chk("reset_instr_valid", instr_valid, 1'b0);
        chk("reset_instr",       instr,       15'd0);
        chk("reset_instr_pc",    instr_pc,    12'd0);
        chk("reset_instr_extra", instr_extra, 1'b0);
        req_log.delete();
        del_log.delete();
        first_valid_rel = 0;
        k_rst = 1'b0;
    endtask

    initial begin
        fill_mem();

        // sequential fetch with 1-cycle memory
        do_reset();
        run(12);
        chk("seq_first_valid_cycle", first_valid_rel, 3);
        chk("seq_req0", req_at(0), 12'o4000);
        chk("seq_req1", req_at(1), 12'o4001);
        chk("seq_req2", req_at(2), 12'o4002);
        chk("seq_pc0",  del_pc_at(0), 12'o4000);
        chk("seq_pc1",  del_pc_at(1), 12'o4001);
        chk("seq_pc2",  del_pc_at(2), 12'o4002);
        chk("seq_word0", del_word_at(0), 15'o04000);

        // backpressure: two words buffered, no third request
        k_ready_mode = 2;
        do_reset();
        run(10);
        chk("bp_req_count", req_log.size(), 2);
        chk("bp_no_pops",   del_log.size(), 0);
        k_ready_mode = 0;
        run(8);
        chk("bp_pc0",  del_pc_at(0), 12'o4000);
        chk("bp_pc1",  del_pc_at(1), 12'o4001);
        chk("bp_req2", req_at(2),    12'o4002);

        // redirect while a slow request is outstanding
        k_lat_min = 4; k_lat_max = 4;
        do_reset();
        run(1);
        k_redir_pc = 12'o2345; k_redir_now = 1'b1;
        run(20);
        chk("redir_req0", req_at(0),    12'o4000);
        chk("redir_req1", req_at(1),    12'o2345);
        chk("redir_pc0",  del_pc_at(0), 12'o2345);

        // extracode tagging across EXTEND / INDEX
        k_lat_min = 1; k_lat_max = 1; k_mem_mode = 1;
        mem_arr[12'o4000] = 15'o00006;
        mem_arr[12'o4001] = 15'o50010;
        mem_arr[12'o4002] = 15'o30020;
        mem_arr[12'o4003] = 15'o30021;
        do_reset();
        run(12);
        chk("ext_extra0", del_extra_at(0), 1'b0);
        chk("ext_extra1", del_extra_at(1), 1'b1);
        chk("ext_extra2", del_extra_at(2), 1'b1);
        chk("ext_extra3", del_extra_at(3), 1'b0);
        chk("ext_word1",  del_word_at(1),  15'o50010);

        // address wrap 7777 -> 0000
        k_mem_mode = 0;
        do_reset();
        run(1);
        k_redir_pc = 12'o7777; k_redir_now = 1'b1;
        run(10);
        chk("wrap_req1", req_at(1),    12'o7777);
        chk("wrap_req2", req_at(2),    12'o0000);
        chk("wrap_pc0",  del_pc_at(0), 12'o7777);
        chk("wrap_pc1",  del_pc_at(1), 12'o0000);

        // halt with a request outstanding, redirect while halted
        k_lat_min = 4; k_lat_max = 4;
        do_reset();
        run(1);
        k_halt_mode = 1;
        run(10);
        chk("halt_req_count", req_log.size(), 1);
        chk("halt_del_count", del_log.size(), 1);
        chk("halt_pc0",       del_pc_at(0),   12'o4000);
        k_redir_pc = 12'o1234; k_redir_now = 1'b1;
        run(3);
        k_halt_mode = 0;
        run(8);
        chk("halt_post_req", req_at(1), 12'o1234);

        // randomized traffic with mid-run resets
        fill_mem();
        k_mem_mode = 1; k_ready_mode = 1; k_halt_mode = 2; k_redir_pct = 4;
        k_lat_min = 1; k_lat_max = 4;
        for (int r = 0; r < 6; r++) begin
            do_reset();
            run(600);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
